// File: rtl/pipe_stage_reg_pkg.sv
// Shared defaults and state encoding for every pipe_stage_reg instance (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_stage_reg_pkg;

  localparam int unsigned PIPE_CTRL_W = 16;
  localparam int unsigned PIPE_DATA_W = 128;
  localparam int unsigned PIPE_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of one pipeline stage.
interface pipe_stage_reg_if
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned DATA_W = PIPE_DATA_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  // Surrounding pipeline: feeds the stage and consumes its output
  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  // The stage register itself
  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready, flush-to-bubble, optional skid entry and stall/bubble counters.
// CTRL is cleared whenever the stage holds no valid instruction; DATA is left as-is.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_reg_if.slave  bus,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic              r_out_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              w_stall_inc;
  logic              w_bubble_inc;

  generate
    if (SKID == 0) begin : g_single
      logic w_in_xfer;
      logic w_out_xfer;

      assign bus.in_ready = bus.out_ready | ~r_out_valid;
      assign w_in_xfer    = bus.in_valid & bus.in_ready;
      assign w_out_xfer   = r_out_valid & bus.out_ready;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_out_valid <= 1'b0;
          r_main_ctrl <= '0;
          r_main_data <= '0;
        end else if (flush) begin
          r_out_valid <= 1'b0;
          r_main_ctrl <= '0;
        end else if (w_in_xfer) begin
          r_out_valid <= 1'b1;
          r_main_ctrl <= bus.in_ctrl;
          r_main_data <= bus.in_data;
        end else if (w_out_xfer) begin
          r_out_valid <= 1'b0;
          r_main_ctrl <= '0;
        end
      end
    end else begin : g_skid
      localparam logic [1:0] S_EMPTY = 2'(ST_EMPTY);
      localparam logic [1:0] S_FULL  = 2'(ST_FULL);
      localparam logic [1:0] S_SKID  = 2'(ST_SKID);

      logic [1:0]        r_state;
      logic [1:0]        w_state_nxt;
      logic              r_in_ready;
      logic [CTRL_W-1:0] r_skid_ctrl;
      logic [DATA_W-1:0] r_skid_data;
      logic              w_in_xfer;
      logic              w_out_xfer;
      logic              w_load_main;
      logic              w_load_skid;
      logic              w_skid_to_main;
      logic              w_clr_ctrl;

      assign bus.in_ready = r_in_ready;
      assign w_in_xfer    = bus.in_valid & r_in_ready;
      assign w_out_xfer   = r_out_valid & bus.out_ready;

      // State register; valid and ready are registered copies of the next-state decode
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end else begin
          r_state     <= w_state_nxt;
          r_in_ready  <= (w_state_nxt != S_SKID);
          r_out_valid <= (w_state_nxt != S_EMPTY);
        end
      end

      always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        w_clr_ctrl     = 1'b0;
        if (flush) begin
          w_state_nxt = S_EMPTY;
          w_clr_ctrl  = 1'b1;
        end else begin
          case (r_state)
            S_EMPTY: begin
              if (w_in_xfer) begin
                w_state_nxt = S_FULL;
                w_load_main = 1'b1;
              end
            end
            S_FULL: begin
              if (w_in_xfer && w_out_xfer) begin
                w_load_main = 1'b1;
              end else if (w_out_xfer) begin
                w_state_nxt = S_EMPTY;
                w_clr_ctrl  = 1'b1;
              end else if (w_in_xfer) begin
                w_state_nxt = S_SKID;
                w_load_skid = 1'b1;
              end
            end
            S_SKID: begin
              if (w_out_xfer) begin
                w_state_nxt    = S_FULL;
                w_skid_to_main = 1'b1;
              end
            end
            default: begin
              w_state_nxt = S_EMPTY;
              w_clr_ctrl  = 1'b1;
            end
          endcase
        end
      end

      // Main holds what is presented downstream; the skid entry absorbs one extra beat
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_main_ctrl <= '0;
          r_main_data <= '0;
          r_skid_ctrl <= '0;
          r_skid_data <= '0;
        end else begin
          if (w_clr_ctrl) begin
            r_main_ctrl <= '0;
          end else if (w_load_main) begin
            r_main_ctrl <= bus.in_ctrl;
          end else if (w_skid_to_main) begin
            r_main_ctrl <= r_skid_ctrl;
          end
          if (w_load_main) begin
            r_main_data <= bus.in_data;
          end else if (w_skid_to_main) begin
            r_main_data <= r_skid_data;
          end
          if (w_load_skid) begin
            r_skid_ctrl <= bus.in_ctrl;
            r_skid_data <= bus.in_data;
          end
        end
      end
    end
  endgenerate

  assign bus.out_valid = r_out_valid;
  assign bus.out_ctrl  = r_main_ctrl;
  assign bus.out_data  = r_main_data;

  assign w_stall_inc  = r_out_valid & ~bus.out_ready;
  assign w_bubble_inc = ~r_out_valid & bus.out_ready;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (w_bubble_inc),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share stimulus and are checked against a queue model.
module tb_pipe_stage_reg;

  localparam int unsigned CW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned NW  = 4;
  localparam int          SAT = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [CW-1:0] s_ctrl;
  logic [DW-1:0] s_data;
  logic          s_ordy;
  logic          s_flush;
  logic          s_clr;
  logic [NW-1:0] a_stall, a_bub, b_stall, b_bub;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) if_a ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) if_b ();

  assign if_a.in_valid  = s_valid;
  assign if_a.in_ctrl   = s_ctrl;
  assign if_a.in_data   = s_data;
  assign if_a.out_ready = s_ordy;
  assign if_b.in_valid  = s_valid;
  assign if_b.in_ctrl   = s_ctrl;
  assign if_b.in_data   = s_data;
  assign if_b.out_ready = s_ordy;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(NW)) u_a (
    .clk        (clk),
    .rst        (rst),
    .bus        (if_a),
    .flush      (s_flush),
    .clr_cnt    (s_clr),
    .stall_cnt  (a_stall),
    .bubble_cnt (a_bub)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(NW)) u_b (
    .clk        (clk),
    .rst        (rst),
    .bus        (if_b),
    .flush      (s_flush),
    .clr_cnt    (s_clr),
    .stall_cnt  (b_stall),
    .bubble_cnt (b_bub)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: index 0 is the SKID=1 stage (capacity 2), index 1 the SKID=0 stage (capacity 1)
  int            m_size   [2];
  logic [CW-1:0] m_qc     [2][2];
  logic [DW-1:0] m_qd     [2][2];
  logic [DW-1:0] m_last_d [2];
  int            m_stall  [2];
  int            m_bub    [2];

  function automatic bit exp_rdy(input int d);
    if (d == 0) return (m_size[0] < 2);
    return (s_ordy || (m_size[1] == 0));
  endfunction

  task automatic step(input int d);
    bit vld, rdy, ix, ox;
    vld = (m_size[d] > 0);
    rdy = exp_rdy(d);
    ix  = s_valid && rdy;
    ox  = vld && s_ordy;
    if (s_clr) m_stall[d] = 0;
    else if (vld && !s_ordy && m_stall[d] < SAT) m_stall[d]++;
    if (s_clr) m_bub[d] = 0;
    else if (!vld && s_ordy && m_bub[d] < SAT) m_bub[d]++;
    if (s_flush) begin
      m_size[d] = 0;
    end else begin
      if (ox) begin
        m_qc[d][0] = m_qc[d][1];
        m_qd[d][0] = m_qd[d][1];
        m_size[d]--;
      end
      if (ix) begin
        m_qc[d][m_size[d]] = s_ctrl;
        m_qd[d][m_size[d]] = s_data;
        m_size[d]++;
      end
    end
    if (m_size[d] > 0) m_last_d[d] = m_qd[d][0];
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        m_size[d]   = 0;
        m_last_d[d] = '0;
        m_stall[d]  = 0;
        m_bub[d]    = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) step(d);
    end
  end

  // Every-cycle comparison of both stages against the model
  always @(negedge clk) begin
    chk("a_in_ready",  64'(if_a.in_ready),  64'(exp_rdy(0)));
    chk("a_out_valid", 64'(if_a.out_valid), 64'(m_size[0] > 0));
    chk("a_out_ctrl",  64'(if_a.out_ctrl),  (m_size[0] > 0) ? 64'(m_qc[0][0]) : 64'd0);
    chk("a_out_data",  64'(if_a.out_data),  64'(m_last_d[0]));
    chk("a_stall_cnt", 64'(a_stall),        64'(m_stall[0]));
    chk("a_bubble_cnt",64'(a_bub),          64'(m_bub[0]));
    chk("b_in_ready",  64'(if_b.in_ready),  64'(exp_rdy(1)));
    chk("b_out_valid", 64'(if_b.out_valid), 64'(m_size[1] > 0));
    chk("b_out_ctrl",  64'(if_b.out_ctrl),  (m_size[1] > 0) ? 64'(m_qc[1][0]) : 64'd0);
    chk("b_out_data",  64'(if_b.out_data),  64'(m_last_d[1]));
    chk("b_stall_cnt", 64'(b_stall),        64'(m_stall[1]));
    chk("b_bubble_cnt",64'(b_bub),          64'(m_bub[1]));
  end

  function automatic logic [DW-1:0] data_of(input logic [CW-1:0] c);
    return {c, ~c};
  endfunction

  // Apply one cycle of inputs, return 1 time unit after the consuming edge
  task automatic cyc(input bit v, input logic [CW-1:0] c, input bit o, input bit f, input bit cl);
    s_valid = v;
    s_ctrl  = c;
    s_data  = data_of(c);
    s_ordy  = o;
    s_flush = f;
    s_clr   = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [31:0] pat;
    pat = 32'b1011_0010_1110_0101_1100_1001_0111_0110;

    rst     = 1'b0;
    s_valid = 1'b1;
    s_ctrl  = 16'hBEEF;
    s_data  = data_of(16'hBEEF);
    s_ordy  = 1'b0;
    s_flush = 1'b0;
    s_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_valid", 64'(if_a.out_valid), 64'd0);
    chk("rst_a_ctrl",  64'(if_a.out_ctrl),  64'd0);
    chk("rst_a_data",  64'(if_a.out_data),  64'd0);
    chk("rst_a_cnt",   64'({a_stall, a_bub}), 64'd0);
    rst = 1'b1;
    cyc(0, 16'h0, 0, 0, 0);
    chk("post_rst_a_ready", 64'(if_a.in_ready), 64'd1);
    chk("post_rst_b_ready", 64'(if_b.in_ready), 64'd1);

    // Streaming 1..8 with a free downstream
    for (int i = 1; i <= 8; i++) begin
      cyc(1, CW'(i), 1, 0, 0);
      chk("stream_valid", 64'(if_a.out_valid), 64'd1);
      chk("stream_ctrl",  64'(if_a.out_ctrl),  64'(i));
      chk("stream_data",  64'(if_a.out_data),  64'(data_of(CW'(i))));
    end
    cyc(0, 16'h0, 1, 0, 0);
    chk("stream_drain_valid", 64'(if_a.out_valid), 64'd0);
    chk("stream_stall",       64'(a_stall),        64'd0);
    chk("stream_bubble",      64'(a_bub),          64'd1);
    cyc(0, 16'h0, 0, 0, 1);

    // Back-pressure: A presented, B absorbed by the skid entry
    cyc(1, 16'h0A0A, 0, 0, 0);
    chk("bp_ctrl_1", 64'(if_a.out_ctrl), 64'h0A0A);
    cyc(1, 16'h0B0B, 0, 0, 0);
    chk("bp_ctrl_2", 64'(if_a.out_ctrl), 64'h0A0A);
    chk("bp_ready_2", 64'(if_a.in_ready), 64'd0);
    cyc(0, 16'h0, 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 0);
    chk("bp_ctrl_4",  64'(if_a.out_ctrl), 64'h0A0A);
    chk("bp_data_4",  64'(if_a.out_data), 64'h0A0A_F5F5);
    chk("bp_ready_4", 64'(if_a.in_ready), 64'd0);
    chk("bp_stall",   64'(a_stall),       64'd3);
    cyc(0, 16'h0, 1, 0, 0);
    chk("bp_ctrl_B",  64'(if_a.out_ctrl), 64'h0B0B);
    chk("bp_valid_B", 64'(if_a.out_valid), 64'd1);
    cyc(0, 16'h0, 1, 0, 0);
    chk("bp_empty_valid", 64'(if_a.out_valid), 64'd0);
    chk("bp_empty_ctrl",  64'(if_a.out_ctrl),  64'd0);

    // Flush while in the skid state, with a new input offered
    cyc(1, 16'h0C0C, 0, 0, 0);
    cyc(1, 16'h0D0D, 0, 0, 0);
    chk("fl_pre_ready", 64'(if_a.in_ready), 64'd0);
    cyc(1, 16'h0E0E, 0, 1, 0);
    chk("fl_valid", 64'(if_a.out_valid), 64'd0);
    chk("fl_ctrl",  64'(if_a.out_ctrl),  64'd0);
    chk("fl_ready", 64'(if_a.in_ready),  64'd1);
    chk("fl_data_hold", 64'(if_a.out_data), 64'h0C0C_F3F3);
    cyc(0, 16'h0, 1, 0, 0);
    chk("fl_after_valid", 64'(if_a.out_valid), 64'd0);
    // Flush with an accepted input in the same cycle
    cyc(1, 16'h0F0F, 0, 0, 0);
    cyc(1, 16'h1111, 1, 1, 0);
    chk("fl2_valid", 64'(if_a.out_valid), 64'd0);
    cyc(0, 16'h0, 1, 0, 0);
    chk("fl2_after_valid", 64'(if_a.out_valid), 64'd0);
    chk("fl2_after_ctrl",  64'(if_a.out_ctrl),  64'd0);

    // Counter saturation and clear-beats-increment
    cyc(0, 16'h0, 1, 0, 1);
    repeat (20) cyc(0, 16'h0, 1, 0, 0);
    chk("sat_a_bubble", 64'(a_bub), 64'd15);
    chk("sat_b_bubble", 64'(b_bub), 64'd15);
    cyc(0, 16'h0, 1, 0, 1);
    chk("clr_a_bubble", 64'(a_bub), 64'd0);

    // SKID=0: combinational ready drop, stable output, flush bubble
    cyc(1, 16'h4848, 0, 0, 0);
    s_ctrl = 16'h4949;
    s_data = data_of(16'h4949);
    #1;
    chk("s0_ready_comb_lo", 64'(if_b.in_ready), 64'd0);
    s_ordy = 1'b1;
    #1;
    chk("s0_ready_comb_hi", 64'(if_b.in_ready), 64'd1);
    cyc(1, 16'h4949, 0, 0, 0);
    chk("s0_hold_1", 64'(if_b.out_ctrl), 64'h4848);
    cyc(1, 16'h4949, 0, 0, 0);
    chk("s0_hold_2", 64'(if_b.out_ctrl), 64'h4848);
    cyc(1, 16'h4949, 0, 1, 0);
    chk("s0_fl_valid", 64'(if_b.out_valid), 64'd0);
    chk("s0_fl_ctrl",  64'(if_b.out_ctrl),  64'd0);
    cyc(0, 16'h0, 1, 0, 0);
    chk("s0_fl_after", 64'(if_b.out_valid), 64'd0);

    // Mixed valid/ready traffic, checked by the model every cycle
    for (int i = 0; i < 32; i++) begin
      cyc((i % 3) != 0, CW'(16'h0100 + i), pat[i], 0, 0);
    end
    repeat (3) cyc(0, 16'h0, 1, 0, 0);

    // Reset mid-operation with the skid entry occupied
    cyc(1, 16'h5A5A, 0, 0, 0);
    cyc(1, 16'h5B5B, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(if_a.out_valid), 64'd0);
    chk("mid_rst_ctrl",  64'(if_a.out_ctrl),  64'd0);
    chk("mid_rst_data",  64'(if_a.out_data),  64'd0);
    chk("mid_rst_stall", 64'(a_stall),        64'd0);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(0, 16'h0, 1, 0, 0);
    chk("mid_rst_no_leak", 64'(if_a.out_valid), 64'd0);
    cyc(0, 16'h0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
